ste_shift_tx: RTL and testbench

//   Parallel-to-serial word transmitter. Drives the serial side of ste_shift_reg
//   (din_i / shift_en_i): bits go out MSB or LSB first, one per clock, with a

---
 rtl/ste_shift_tx.sv | 139 +++++++++++++
 tb/tb_ste_shift_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ste_shift_tx.sv
// Parallel-to-serial word transmitter feeding the serial side of ste_shift_reg.
// It accepts a word on a valid/ready handshake and sends it one bit per clock,
// MSB or LSB first. It then holds a fixed idle gap before the next word.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a word, ready_o high unless clr_i
//   ST_SHIFT | word in flight, one bit per cycle on dout_o
//   ST_GAP   | GAP_CYC idle cycles; last cycle may accept the next word
module ste_shift_tx #(
    parameter int SHIFT_W   = 24,
    parameter int GAP_CYC   = 5,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [SHIFT_W-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               clr_i,
    output logic               dout_o,
    output logic               shift_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   tx_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int BIT_W    = $clog2(SHIFT_W);
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [SHIFT_W-1:0] sreg_q;
    // bits still to send after the one currently on dout_o
    logic [BIT_W-1:0]   bit_cnt_q;
    // gap cycles remaining after the current one
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               last_bit;
    logic               gap_end;
    logic               accept;

    function automatic logic lead_bit(input logic [SHIFT_W-1:0] v);
        return MSB_FIRST ? v[SHIFT_W-1] : v[0];
    endfunction

    function automatic logic [SHIFT_W-1:0] advance(input logic [SHIFT_W-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    assign gap_end  = (state_q == ST_GAP) && (gap_cnt_q == '0);

    // Ready in idle, in the final gap cycle, or on the last bit when there is
    // no gap. This lets words run back to back with exactly GAP_CYC idle cycles.
    assign ready_o = !clr_i && ((state_q == ST_IDLE) || gap_end ||
                                ((GAP_CYC == 0) && last_bit));
    assign accept  = valid_i && ready_o;

    // Next-state selection; clr_i wins over everything, accept over timeouts.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            dout_o     <= 1'b0;
            shift_en_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            tx_cnt_o   <= '0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != ST_IDLE);
            done_o  <= 1'b0;
            if (clr_i) begin
                shift_en_o <= 1'b0;
                dout_o     <= 1'b0;
                sreg_q     <= '0;
                bit_cnt_q  <= '0;
                gap_cnt_q  <= '0;
            end else if (accept) begin
                // first bit goes straight to the output register
                shift_en_o <= 1'b1;
                dout_o     <= lead_bit(data_i);
                sreg_q     <= advance(data_i);
                bit_cnt_q  <= BIT_W'(SHIFT_W - 1);
            end else if (state_q == ST_SHIFT) begin
                if (bit_cnt_q != '0) begin
                    dout_o    <= lead_bit(sreg_q);
                    sreg_q    <= advance(sreg_q);
                    bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(1)) begin
                        done_o   <= 1'b1;
                        tx_cnt_o <= tx_cnt_o + CNT_W'(1);
                    end
                end else begin
                    shift_en_o <= 1'b0;
                    dout_o     <= 1'b0;
                    gap_cnt_q  <= GAP_W'(GAP_LOAD);
                end
            end else if (state_q == ST_GAP) begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ste_shift_tx.sv
// Bench for ste_shift_tx. Three instances share the inputs: default build,
// LSB-first with no gap, and a 2-bit word counter. `sel` picks the one
// being checked. Expected behaviour comes from a per-cycle timeline: each
// accepted word owns W bit slots followed by G gap slots.
module tb_ste_shift_tx;
    localparam int W    = 24;
    localparam int MAXC = 1024;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         clr_i;

    logic        rdy0, dout0, en0, busy0, done0;
    logic [15:0] cnt0;
    logic        rdy1, dout1, en1, busy1, done1;
    logic [15:0] cnt1;
    logic        rdy2, dout2, en2, busy2, done2;
    logic [1:0]  cnt2;

    ste_shift_tx #(.SHIFT_W(W), .GAP_CYC(5), .MSB_FIRST(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy0),
        .clr_i(clr_i), .dout_o(dout0), .shift_en_o(en0), .busy_o(busy0), .done_o(done0),
        .tx_cnt_o(cnt0));
    ste_shift_tx #(.SHIFT_W(W), .GAP_CYC(0), .MSB_FIRST(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy1),
        .clr_i(clr_i), .dout_o(dout1), .shift_en_o(en1), .busy_o(busy1), .done_o(done1),
        .tx_cnt_o(cnt1));
    ste_shift_tx #(.SHIFT_W(W), .GAP_CYC(5), .MSB_FIRST(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy2),
        .clr_i(clr_i), .dout_o(dout2), .shift_en_o(en2), .busy_o(busy2), .done_o(done2),
        .tx_cnt_o(cnt2));

    always #5 clk = ~clk;

    int          sel;
    logic        obs_rdy, obs_dout, obs_en, obs_busy, obs_done;
    logic [15:0] obs_cnt;

    // Route the instance under test onto the observation signals.
    always_comb begin
        obs_rdy = rdy0; obs_dout = dout0; obs_en = en0;
        obs_busy = busy0; obs_done = done0; obs_cnt = cnt0;
        if (sel == 1) begin
            obs_rdy = rdy1; obs_dout = dout1; obs_en = en1;
            obs_busy = busy1; obs_done = done1; obs_cnt = cnt1;
        end else if (sel == 2) begin
            obs_rdy = rdy2; obs_dout = dout2; obs_en = en2;
            obs_busy = busy2; obs_done = done2; obs_cnt = {14'b0, cnt2};
        end
    end

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] words_q[$];
    bit           exp_en[MAXC];
    bit           exp_dout[MAXC];
    bit           exp_done[MAXC];
    bit           exp_busy[MAXC];

    task automatic do_reset();
        valid_i = 1'b0;
        clr_i   = 1'b0;
        data_i  = '0;
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    // Send everything in words_q through the selected instance and check every
    // output on every cycle against the timeline model.
    // hold: source presents the next word immediately after each accept.
    // clr_after: if >0, pulse clr_i that many cycles after the first accept.
    task automatic run_scenario(input bit hold, input int max_delay, input int clr_after);
        int           g;
        bit           msb;
        int           cmask;
        int           cyc;
        int           next_ready;
        int           clr_cyc;
        int           cnt;
        int           wait_n;
        bit           acc_last;
        bit           rdy_exp;
        logic [W-1:0] w;
        g     = (sel == 1) ? 0 : 5;
        msb   = (sel != 1);
        cmask = (sel == 2) ? 3 : 16'hffff;
        for (int k = 0; k < MAXC; k++) begin
            exp_en[k] = 0; exp_dout[k] = 0; exp_done[k] = 0; exp_busy[k] = 0;
        end
        cyc = 0; next_ready = 0; clr_cyc = -1; cnt = 0; wait_n = 0; acc_last = 0;
        valid_i = 1'b0;
        clr_i   = 1'b0;
        forever begin
            @(negedge clk);
            cnt += int'(exp_done[cyc]);
            n_cmp++;
            if (obs_en !== exp_en[cyc]) begin
                n_err++;
                $display("FAIL shift_en sel=%0d cyc=%0d got=%b want=%b", sel, cyc, obs_en, exp_en[cyc]);
            end
            n_cmp++;
            if (obs_dout !== exp_dout[cyc]) begin
                n_err++;
                $display("FAIL dout sel=%0d cyc=%0d got=%b want=%b", sel, cyc, obs_dout, exp_dout[cyc]);
            end
            n_cmp++;
            if (obs_done !== exp_done[cyc]) begin
                n_err++;
                $display("FAIL done sel=%0d cyc=%0d got=%b want=%b", sel, cyc, obs_done, exp_done[cyc]);
            end
            n_cmp++;
            if (obs_busy !== exp_busy[cyc]) begin
                n_err++;
                $display("FAIL busy sel=%0d cyc=%0d got=%b want=%b", sel, cyc, obs_busy, exp_busy[cyc]);
            end
            n_cmp++;
            if (obs_cnt !== 16'(cnt & cmask)) begin
                n_err++;
                $display("FAIL tx_cnt sel=%0d cyc=%0d got=%0d want=%0d", sel, cyc, obs_cnt, cnt & cmask);
            end
            if (words_q.size() == 0 && !valid_i && cyc >= next_ready + 2) break;
            if (cyc >= MAXC - W - 8) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout sel=%0d cyc=%0d words_left=%0d want=0", sel, cyc, words_q.size());
                break;
            end
            if (acc_last) begin
                valid_i  = 1'b0;
                acc_last = 0;
                wait_n   = hold ? 0 : $urandom_range(max_delay, 0);
            end
            if (!valid_i && words_q.size() > 0) begin
                if (wait_n == 0) begin
                    valid_i = 1'b1;
                    data_i  = words_q[0];
                end else begin
                    wait_n--;
                end
            end
            if (!valid_i) data_i = W'($urandom);
            clr_i = (cyc == clr_cyc);
            #1;
            rdy_exp = !clr_i && (cyc >= next_ready);
            n_cmp++;
            if (obs_rdy !== rdy_exp) begin
                n_err++;
                $display("FAIL ready sel=%0d cyc=%0d got=%b want=%b", sel, cyc, obs_rdy, rdy_exp);
            end
            if (valid_i && rdy_exp) begin
                w = words_q.pop_front();
                for (int i = 0; i < W; i++) begin
                    exp_en[cyc + 1 + i]   = 1;
                    exp_dout[cyc + 1 + i] = msb ? w[W - 1 - i] : w[i];
                end
                for (int i = 1; i <= W + g; i++) exp_busy[cyc + i] = 1;
                exp_done[cyc + W] = 1;
                next_ready = cyc + W + g;
                acc_last   = 1;
                if (clr_after > 0 && clr_cyc < 0) clr_cyc = cyc + clr_after;
            end
            if (clr_i) begin
                for (int k = cyc + 1; k < MAXC; k++) begin
                    exp_en[k] = 0; exp_dout[k] = 0; exp_done[k] = 0; exp_busy[k] = 0;
                end
                next_ready = cyc + 1;
            end
            cyc++;
        end
        clr_i   = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({en0, dout0, done0, busy0} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=0000", {en0, dout0, done0, busy0});
        end
        n_cmp++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 2'd0) begin
            n_err++;
            $display("FAIL reset_tx_cnt got=%0d/%0d/%0d want=0/0/0", cnt0, cnt1, cnt2);
        end
        n_cmp++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ready got=%b want=111", {rdy0, rdy1, rdy2});
        end
    endtask

    task automatic test_single_word();
        do_reset();
        sel = 0;
        words_q.push_back(24'hdfeabc);
        run_scenario(1'b1, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        sel = 0;
        words_q.push_back(24'haaaaaa);
        words_q.push_back(24'h555555);
        run_scenario(1'b1, 0, 0);
    endtask

    task automatic test_clear();
        do_reset();
        sel = 0;
        words_q.push_back(24'hffffff);
        words_q.push_back(24'h123456);
        run_scenario(1'b1, 0, 10);
    endtask

    task automatic test_lsb_no_gap();
        do_reset();
        sel = 1;
        words_q.push_back(24'h000001);
        words_q.push_back(24'h800000);
        run_scenario(1'b1, 0, 0);
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        sel = 2;
        for (int i = 0; i < 5; i++) words_q.push_back(W'($urandom));
        run_scenario(1'b0, 2, 0);
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            sel = s;
            for (int i = 0; i < 10; i++) words_q.push_back(W'($urandom));
            run_scenario(1'b0, 3, 0);
            do_reset();
            for (int i = 0; i < 4; i++) words_q.push_back(W'($urandom));
            run_scenario(1'b1, 0, $urandom_range(W + 6, 1));
        end
    endtask

    task automatic test_reset_midword();
        do_reset();
        sel = 0;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 24'hfedcba;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (en0 !== 1'b1) begin
            n_err++;
            $display("FAIL midword_active got=%b want=1", en0);
        end
        #2 reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({en0, dout0, done0, busy0} !== 4'b0000 || cnt0 !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset got=%b cnt=%0d want=0000 cnt=0", {en0, dout0, done0, busy0}, cnt0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        words_q.push_back(24'h234567);
        run_scenario(1'b1, 0, 0);
    endtask

    initial begin
        sel     = 0;
        reset_i = 1'b1;
        valid_i = 1'b0;
        clr_i   = 1'b0;
        data_i  = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_clear();
        test_lsb_no_gap();
        test_cnt_wrap();
        test_random();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
